// File: rtl/grey_to_bcd_seq.sv
// Bit-serial Gray-to-binary decoder: resolves one bit per clock, MSB first, with valid/ready on both sides.
// Defining GREY_DEC_ADJ_CHECK_EN adds the adj_err output flagging non-adjacent consecutive Gray words.
module grey_to_bcd_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] grey,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] bcd
`ifdef GREY_DEC_ADJ_CHECK_EN
    ,
    output logic         adj_err
`endif
);
    localparam int            IW        = $clog2(N);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] IDX_START = IW'(N - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_g;
    logic [N-1:0]  r_acc;
    logic [IW-1:0] r_idx;
    logic          w_accept;
    logic          w_consume;
    logic          w_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_CONV;
            end
            S_CONV: begin
                if (r_idx == '0) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_consume = (r_state == S_DONE) && out_ready;
    // Each binary bit is the previous (higher) binary bit XOR the Gray bit at the same position.
    assign w_bit     = r_acc[r_idx + IDX_ONE] ^ r_g[r_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_g   <= '0;
            r_acc <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_g   <= grey;
            r_acc <= {grey[N-1], {(N-1){1'b0}}};
            r_idx <= IDX_START;
        end else if (r_state == S_CONV) begin
            r_acc[r_idx] <= w_bit;
            r_idx        <= r_idx - IDX_ONE;
        end
    end

    assign bcd = out_valid ? r_acc : '0;

`ifdef GREY_DEC_ADJ_CHECK_EN
    logic [N-1:0] r_prev;
    logic         r_seen;
    logic         r_adj;

    function automatic int unsigned f_popcount(input logic [N-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < N; i++) c = c + {31'd0, v[i]};
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_seen <= 1'b0;
            r_adj  <= 1'b0;
        end else if (w_accept) begin
            r_prev <= grey;
            r_seen <= 1'b1;
            r_adj  <= r_seen && (f_popcount(grey ^ r_prev) > 32'd1);
        end else if (w_consume) begin
            r_adj  <= 1'b0;
        end
    end

    assign adj_err = r_adj;
`else
    logic w_unused;
    assign w_unused = w_consume;
`endif

endmodule

// File: tb/tb_grey_to_bcd_seq.sv
// Self-checking bench for grey_to_bcd_seq: vector table, round trip, random traffic, stalls, resets, widths.
module tb_grey_to_bcd_seq;
    logic        clk;
    logic        rst_n;
    logic        iv8, rdy8, ov8, or8;
    logic [7:0]  g8, b8;
    logic        iv2, rdy2, ov2, or2;
    logic [1:0]  g2, b2;
    logic        iv16, rdy16, ov16, or16;
    logic [15:0] g16, b16;
    logic        adj8, adj2, adj16;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;
    vec_t tbl[6];

    grey_to_bcd_seq #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8), .grey(g8),
        .out_valid(ov8), .out_ready(or8), .bcd(b8)
`ifdef GREY_DEC_ADJ_CHECK_EN
        , .adj_err(adj8)
`endif
    );

    grey_to_bcd_seq #(.N(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(rdy2), .grey(g2),
        .out_valid(ov2), .out_ready(or2), .bcd(b2)
`ifdef GREY_DEC_ADJ_CHECK_EN
        , .adj_err(adj2)
`endif
    );

    grey_to_bcd_seq #(.N(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy16), .grey(g16),
        .out_valid(ov16), .out_ready(or16), .bcd(b16)
`ifdef GREY_DEC_ADJ_CHECK_EN
        , .adj_err(adj16)
`endif
    );

`ifndef GREY_DEC_ADJ_CHECK_EN
    assign adj8  = 1'b0;
    assign adj2  = 1'b0;
    assign adj16 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_g2b(input logic [15:0] g);
        logic [15:0] b;
        b = g;
        for (int s = 1; s < 16; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic cur_rdy(input int w);
        case (w)
            2:       return rdy2;
            16:      return rdy16;
            default: return rdy8;
        endcase
    endfunction

    function automatic logic cur_ov(input int w);
        case (w)
            2:       return ov2;
            16:      return ov16;
            default: return ov8;
        endcase
    endfunction

    function automatic logic [15:0] cur_b(input int w);
        case (w)
            2:       return {14'd0, b2};
            16:      return b16;
            default: return {8'd0, b8};
        endcase
    endfunction

    task automatic set_in(input int w, input logic v, input logic [15:0] g);
        case (w)
            2:       begin iv2 = v; g2 = g[1:0]; end
            16:      begin iv16 = v; g16 = g; end
            default: begin iv8 = v; g8 = g[7:0]; end
        endcase
    endtask

    task automatic set_or(input int w, input logic v);
        case (w)
            2:       or2 = v;
            16:      or16 = v;
            default: or8 = v;
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Accepts one word, measures edges from accept to out_valid, captures the result, then consumes it.
    task automatic run_dec(input int w, input logic [15:0] g, input int stall,
                           output logic [15:0] b, output int lat, output logic adj);
        int j;
        b   = '0;
        lat = -1;
        adj = 1'b0;
        @(negedge clk);
        j = 0;
        while (!cur_rdy(w) && j < 50) begin
            @(negedge clk);
            j++;
        end
        set_in(w, 1'b1, g);
        @(posedge clk);
        #1 set_in(w, 1'b0, '0);
        j = 0;
        do begin
            @(posedge clk);
            j++;
            @(negedge clk);
        end while (!cur_ov(w) && j < 60);
        if (!cur_ov(w)) begin
            n_tests++;
            n_fail++;
            $display("FAIL dec_timeout w=%0d: no out_valid after %0d edges, required within 60", w, j);
            return;
        end
        lat = j;
        b   = cur_b(w);
        adj = (w == 8) ? adj8 : ((w == 2) ? adj2 : adj16);
        repeat (stall) @(negedge clk);
        set_or(w, 1'b1);
        @(posedge clk);
        #1 set_or(w, 1'b0);
    endtask

    logic [15:0] rb, rg, exp16;
    int          lat, j;
    logic        ra;
    logic [7:0]  adj_words[5];
    logic        adj_exp[5];

    initial begin
        tbl[0] = '{8'b11101110, 8'b10110100};
        tbl[1] = '{8'b00001011, 8'b00001101};
        tbl[2] = '{8'b11011110, 8'b10010100};
        tbl[3] = '{8'h80, 8'hFF};
        tbl[4] = '{8'hFF, 8'hAA};
        tbl[5] = '{8'h00, 8'h00};
        adj_words = '{8'h00, 8'h01, 8'h03, 8'h00, 8'h00};
        adj_exp   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        iv8 = 0; or8 = 0; g8 = '0;
        iv2 = 0; or2 = 0; g2 = '0;
        iv16 = 0; or16 = 0; g16 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, ov8}, 32'd0);
        check("rst_bcd", {24'd0, b8}, 32'd0);
        check("rst_in_ready", {31'd0, rdy8}, 32'd1);
        check("rst_adj_err", {31'd0, adj8}, 32'd0);
        check("rst_in_ready16", {31'd0, rdy16}, 32'd1);
        rst_n = 1'b1;

        // Single decode with latency and return-to-idle
        run_dec(8, 16'h00EE, 0, rb, lat, ra);
        check("t1_bcd", {16'd0, rb}, 32'h00B4);
        check("t1_latency", lat, 7);
        @(negedge clk);
        check("t1_in_ready_after", {31'd0, rdy8}, 32'd1);
        check("t1_out_valid_after", {31'd0, ov8}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_dec(8, {8'd0, tbl[i].g}, i % 3, rb, lat, ra);
            check($sformatf("tbl[%0d] g=%02h", i, tbl[i].g), {16'd0, rb}, {24'd0, tbl[i].b});
        end

        for (int b = 0; b < 256; b++) begin
            rg = 16'(b) ^ (16'(b) >> 1);
            run_dec(8, rg, 0, rb, lat, ra);
            check($sformatf("roundtrip b=%02h", b), {16'd0, rb}, b);
        end

        for (int i = 0; i < 60; i++) begin
            rg = {8'd0, 8'($urandom)};
            exp16 = model_g2b(rg);
            run_dec(8, rg, $urandom_range(0, 3), rb, lat, ra);
            check($sformatf("rand8 g=%02h", rg[7:0]), {16'd0, rb}, {16'd0, exp16});
            check("rand8_latency", lat, 7);
        end

        // Backpressure: 20-cycle stall with an ignored in_valid pulse
        @(negedge clk);
        iv8 = 1'b1;
        g8  = 8'h3C;
        @(posedge clk);
        #1 iv8 = 1'b0;
        j = 0;
        do begin
            @(negedge clk);
            j++;
        end while (!ov8 && j < 40);
        exp16 = model_g2b(16'h003C);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin iv8 = 1'b1; g8 = 8'hFF; end
            if (i == 7) iv8 = 1'b0;
            check($sformatf("stall_bcd[%0d]", i), {24'd0, b8}, {16'd0, exp16});
            check($sformatf("stall_out_valid[%0d]", i), {31'd0, ov8}, 32'd1);
            check($sformatf("stall_in_ready[%0d]", i), {31'd0, rdy8}, 32'd0);
            @(negedge clk);
        end
        or8 = 1'b1;
        @(posedge clk);
        #1 or8 = 1'b0;
        @(negedge clk);
        check("bp_in_ready_after", {31'd0, rdy8}, 32'd1);
        repeat (12) @(negedge clk);
        check("bp_no_phantom_valid", {31'd0, ov8}, 32'd0);
        run_dec(8, 16'h0055, 0, rb, lat, ra);
        check("bp_next_bcd", {16'd0, rb}, {16'd0, model_g2b(16'h0055)});

        // Reset during CONV
        @(negedge clk);
        iv8 = 1'b1;
        g8  = 8'hA5;
        @(posedge clk);
        #1 iv8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_out_valid", {31'd0, ov8}, 32'd0);
        check("midrst_bcd", {24'd0, b8}, 32'd0);
        check("midrst_in_ready", {31'd0, rdy8}, 32'd1);
        run_dec(8, 16'h0080, 0, rb, lat, ra);
        check("midrst_next_bcd", {16'd0, rb}, 32'h00FF);

        // Reset in DONE with out_ready high on the same edge
        @(negedge clk);
        iv8 = 1'b1;
        g8  = 8'h0F;
        @(posedge clk);
        #1 iv8 = 1'b0;
        j = 0;
        do begin
            @(negedge clk);
            j++;
        end while (!ov8 && j < 40);
        check("done_reached", {31'd0, ov8}, 32'd1);
        rst_n = 1'b0;
        or8   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        or8   = 1'b0;
        check("donerst_out_valid", {31'd0, ov8}, 32'd0);
        check("donerst_bcd", {24'd0, b8}, 32'd0);
        check("donerst_in_ready", {31'd0, rdy8}, 32'd1);

        // Boundary widths
        run_dec(2, 16'h0002, 0, rb, lat, ra);
        check("n2_bcd", {16'd0, rb}, 32'h3);
        check("n2_latency", lat, 1);
        for (int i = 0; i < 4; i++) begin
            run_dec(2, 16'(i), 1, rb, lat, ra);
            check($sformatf("n2 g=%0d", i), {16'd0, rb}, {16'd0, model_g2b(16'(i))});
        end
        run_dec(16, 16'h8000, 0, rb, lat, ra);
        check("n16_bcd", {16'd0, rb}, 32'hFFFF);
        check("n16_latency", lat, 15);
        for (int i = 0; i < 10; i++) begin
            rg = 16'($urandom);
            run_dec(16, rg, $urandom_range(0, 2), rb, lat, ra);
            check($sformatf("rand16 g=%04h", rg), {16'd0, rb}, {16'd0, model_g2b(rg)});
        end

`ifdef GREY_DEC_ADJ_CHECK_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_dec(8, {8'd0, adj_words[i]}, 0, rb, lat, ra);
            check($sformatf("adj[%0d] g=%02h", i, adj_words[i]), {31'd0, ra}, {31'd0, adj_exp[i]});
            check($sformatf("adj_bcd[%0d]", i), {16'd0, rb}, {16'd0, model_g2b({8'd0, adj_words[i]})});
        end
        @(negedge clk);
        check("adj_cleared_on_consume", {31'd0, adj8}, 32'd0);
        do_reset();
        run_dec(8, 16'h00FF, 0, rb, lat, ra);
        check("adj_first_after_reset", {31'd0, ra}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
